// File: rtl/mem_store_if.sv
// Store-request / RAM-write bundle between the MEM stage, mem_store_ctrl and the byte-wide RAM.
interface mem_store_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32
);
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [1:0]        st_size;
    logic              st_ready;
    logic              st_done;
    logic              st_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_dout;
    logic              mem_we;

    // Pipeline / bench side: issues stores and observes the RAM port.
    modport master (
        output st_req, st_addr, st_data, st_size,
        input  st_ready, st_done, st_err, mem_addr, mem_dout, mem_we
    );

    // Store controller side.
    modport slave (
        input  st_req, st_addr, st_data, st_size,
        output st_ready, st_done, st_err, mem_addr, mem_dout, mem_we
    );
endinterface

// File: rtl/mem_store_ctrl.sv
// Serialises one 8/16/32-bit store onto the byte-wide RAM port, little-endian, one byte per cycle.
// Optional MEM_STORE_ALIGN_CHECK_EN rejects misaligned SH/SW with st_done+st_err and no RAM write.
module mem_store_ctrl #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    mem_store_if.slave  bus
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;

    logic [CNT_W-1:0]  req_len_c;
    logic              misalign_c;

    // Byte count of the incoming request; size 11 behaves as a word store.
    always_comb begin
        req_len_c = CNT_W'(4);
        case (bus.st_size)
            2'b00:   req_len_c = CNT_W'(1);
            2'b01:   req_len_c = CNT_W'(2);
            default: req_len_c = CNT_W'(4);
        endcase
    end

`ifdef MEM_STORE_ALIGN_CHECK_EN
    assign misalign_c = ((bus.st_size == 2'b01) && bus.st_addr[0]) ||
                        (bus.st_size[1] && (bus.st_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    // State and output registers; outputs are computed one cycle ahead in the comb block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    // Next state and next registered outputs; cnt counts bytes already placed on the port.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        data_d  = data_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.st_req) begin
                    ready_d = 1'b0;
                    if (misalign_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        addr_d  = bus.st_addr;
                        dout_d  = bus.st_data[7:0];
                        data_d  = bus.st_data >> 8;
                        len_d   = req_len_c;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end

            S_WRITE: begin
                if (cnt_q == len_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    dout_d = data_q[7:0];
                    data_d = data_q >> 8;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                cnt_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.st_ready = ready_q;
    assign bus.st_done  = done_q;
    assign bus.st_err   = err_q;
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_dout = dout_q;

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Scoreboard bench for mem_store_ctrl: directed stores push expected RAM writes / done pulses,
// a negedge monitor pops and compares them, including the cycle each event must appear in.
module tb_mem_store_ctrl;

    localparam int unsigned ADDR_W = 17;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_store_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    mem_store_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [16:0] addr;
        logic [7:0]  data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    int edges    = 0;
    int n_checks = 0;
    int n_fail   = 0;

    // Number of the upcoming posedge, i.e. the edge that consumes what is visible now.
    always @(posedge clk) edges <= edges + 1;

    function automatic int now_cyc();
        return edges + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, now_cyc());
        end
    endtask

    task automatic exp_wr(input int cyc, input logic [16:0] a, input logic [7:0] d);
        exp_t e;
        e = '{1'b0, cyc, a, d, 1'b0};
        sb.push_back(e);
    endtask

    task automatic exp_done(input int cyc, input logic err);
        exp_t e;
        e = '{1'b1, cyc, 17'h0, 8'h0, err};
        sb.push_back(e);
    endtask

    // Monitor: every RAM write and every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write_addr", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wr_kind", 32'(1'b0), 32'(e.is_done));
                check("wr_cycle", 32'(now_cyc()), 32'(e.cyc));
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_data", 32'(bus.mem_dout), 32'(e.data));
            end
        end
        if (bus.st_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(bus.st_done), 32'(1'b0));
            end else begin
                e = sb.pop_front();
                check("done_kind", 32'(1'b1), 32'(e.is_done));
                check("done_cycle", 32'(now_cyc()), 32'(e.cyc));
                check("done_err", 32'(bus.st_err), 32'(e.err));
            end
        end else if (bus.st_err !== 1'b0) begin
            check("err_without_done", 32'(bus.st_err), 32'(1'b0));
        end
    end

    // Called at a negedge while idle; scrambles the inputs after acceptance.
    task automatic issue(input logic [1:0] size, input logic [16:0] addr, input logic [31:0] data);
        check("ready_before_req", 32'(bus.st_ready), 32'(1'b1));
        bus.st_req  = 1'b1;
        bus.st_size = size;
        bus.st_addr = addr;
        bus.st_data = data;
        @(negedge clk);
        bus.st_req  = 1'b0;
        bus.st_size = 2'b00;
        bus.st_addr = 17'h1ABCD;
        bus.st_data = 32'h5A5A_5A5A;
    endtask

    task automatic wait_ready(input int rdy_cyc);
        while (now_cyc() < rdy_cyc) begin
            check("busy_ready_low", 32'(bus.st_ready), 32'(1'b0));
            @(negedge clk);
        end
        check("ready_return", 32'(bus.st_ready), 32'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.st_req  = 1'b0;
        bus.st_size = 2'b00;
        bus.st_addr = '0;
        bus.st_data = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.st_ready), 32'(1'b1));
        check("rst_we", 32'(bus.mem_we), 32'(1'b0));
        check("rst_done", 32'(bus.st_done), 32'(1'b0));
        check("rst_err", 32'(bus.st_err), 32'(1'b0));
        check("rst_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_dout", 32'(bus.mem_dout), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // SW aligned
        t = now_cyc();
        exp_wr(t + 1, 17'h00100, 8'hEF);
        exp_wr(t + 2, 17'h00101, 8'hBE);
        exp_wr(t + 3, 17'h00102, 8'hAD);
        exp_wr(t + 4, 17'h00103, 8'hDE);
        exp_done(t + 5, 1'b0);
        issue(2'b10, 17'h00100, 32'hDEAD_BEEF);
        wait_ready(t + 6);

        // SB back-to-back
        t = now_cyc();
        exp_wr(t + 1, 17'h00042, 8'h78);
        exp_done(t + 2, 1'b0);
        issue(2'b00, 17'h00042, 32'h1234_5678);
        wait_ready(t + 3);

        // SH
        t = now_cyc();
        exp_wr(t + 1, 17'h00050, 8'h34);
        exp_wr(t + 2, 17'h00051, 8'h12);
        exp_done(t + 3, 1'b0);
        issue(2'b01, 17'h00050, 32'hAAAA_1234);
        wait_ready(t + 4);

        // Size 11 behaves as SW
        t = now_cyc();
        exp_wr(t + 1, 17'h00300, 8'h44);
        exp_wr(t + 2, 17'h00301, 8'h33);
        exp_wr(t + 3, 17'h00302, 8'h22);
        exp_wr(t + 4, 17'h00303, 8'h11);
        exp_done(t + 5, 1'b0);
        issue(2'b11, 17'h00300, 32'h1122_3344);
        wait_ready(t + 6);

        // Address wrap (misaligned SW, so rejected when the check is built in)
        t = now_cyc();
`ifdef MEM_STORE_ALIGN_CHECK_EN
        exp_done(t + 1, 1'b1);
        issue(2'b10, 17'h1FFFE, 32'h4433_2211);
        wait_ready(t + 2);
`else
        exp_wr(t + 1, 17'h1FFFE, 8'h11);
        exp_wr(t + 2, 17'h1FFFF, 8'h22);
        exp_wr(t + 3, 17'h00000, 8'h33);
        exp_wr(t + 4, 17'h00001, 8'h44);
        exp_done(t + 5, 1'b0);
        issue(2'b10, 17'h1FFFE, 32'h4433_2211);
        wait_ready(t + 6);
`endif

        // Misaligned SW at 0x102
        t = now_cyc();
`ifdef MEM_STORE_ALIGN_CHECK_EN
        exp_done(t + 1, 1'b1);
        issue(2'b10, 17'h00102, 32'h0A0B_0C0D);
        wait_ready(t + 2);
`else
        exp_wr(t + 1, 17'h00102, 8'h0D);
        exp_wr(t + 2, 17'h00103, 8'h0C);
        exp_wr(t + 3, 17'h00104, 8'h0B);
        exp_wr(t + 4, 17'h00105, 8'h0A);
        exp_done(t + 5, 1'b0);
        issue(2'b10, 17'h00102, 32'h0A0B_0C0D);
        wait_ready(t + 6);
`endif

        // Busy request ignored, then reset after the second byte aborts the store
        t = now_cyc();
        exp_wr(t + 1, 17'h00200, 8'h01);
        exp_wr(t + 2, 17'h00201, 8'h02);
        issue(2'b10, 17'h00200, 32'h0403_0201);
        bus.st_req  = 1'b1;
        bus.st_size = 2'b00;
        bus.st_addr = 17'h00400;
        bus.st_data = 32'h0000_00FF;
        @(negedge clk);
        bus.st_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(bus.st_ready), 32'(1'b1));
        check("abort_we", 32'(bus.mem_we), 32'(1'b0));
        check("abort_done", 32'(bus.st_done), 32'(1'b0));
        check("abort_addr", 32'(bus.mem_addr), 32'h0);
        bus.st_req  = 1'b1;
        bus.st_size = 2'b00;
        bus.st_addr = 17'h00500;
        @(negedge clk);
        rst = 1'b0;
        bus.st_req = 1'b0;
        check("req_during_rst_dropped", 32'(bus.st_ready), 32'(1'b1));
        repeat (8) @(negedge clk);
        check("idle_ready", 32'(bus.st_ready), 32'(1'b1));

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
